// File: rtl/usb_rx_front.sv
// USB full-speed receive front end: synchronize D+/D-, recover bit timing, NRZI-decode, unstuff, assemble bytes, flag EOP/errors.
// Latency: a byte is presented about 2 sync flops + 4 clk after the mid-bit sample of its last bit; eop follows the SE0 sample by 1 clk.
// No backpressure: the decoder must accept every write_enable strobe (2 clk wide, at least 64 clk apart).
//
// Ports:
//   clk          - system clock, 8 clk per USB bit
//   n_rst        - asynchronous active-low reset
//   d_plus       - raw D+ line, asynchronous to clk
//   d_minus      - raw D- line, asynchronous to clk
//   rx_data      - last completed byte, first received bit in bit 0
//   write_enable - byte-valid strobe, high for exactly 2 clk per byte
//   eop          - high from the SE0 sample until the first J sample
//   rcv_error    - sticky error, cleared only by a valid sync byte or reset
module usb_rx_front (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [7:0] rx_data,
  output logic       write_enable,
  output logic       eop,
  output logic       rcv_error
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECEIVE,
    ERR_WAIT,
    EOP_WAIT
  } state_t;

  state_t     state;

  // Two-flop synchronizers; reset values represent the idle J state.
  logic       dp_s1;
  logic       dp_s2;
  logic       dm_s1;
  logic       dm_s2;
  // Previous synchronized D+, used for edge detection (timing recovery and start of packet).
  logic       dp_prev;

  logic [2:0] timer;        // position within the current bit cell
  logic       prev_sample;  // last sampled D+ level, reference for NRZI decoding
  logic [7:0] shift;        // byte being assembled, first bit ends up in bit 0
  logic [2:0] bit_cnt;      // kept (non-stuffed) bits in the current byte
  logic [2:0] ones;         // consecutive decoded 1s, spans sync and data
  logic       we_hold;      // keeps write_enable high for its second clk

  logic       dp_edge;
  logic       sample;
  logic       se0;
  logic       line_j;
  logic       nrzi_bit;
  logic [7:0] shift_next;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_s1   <= 1'b1;
      dp_s2   <= 1'b1;
      dm_s1   <= 1'b0;
      dm_s2   <= 1'b0;
      dp_prev <= 1'b1;
    end else begin
      dp_s1   <= d_plus;
      dp_s2   <= dp_s1;
      dm_s1   <= d_minus;
      dm_s2   <= dm_s1;
      dp_prev <= dp_s2;
    end
  end

  always_comb begin
    dp_edge    = dp_s2 ^ dp_prev;
    sample     = (timer == 3'd3);
    se0        = !dp_s2 && !dm_s2;
    line_j     = dp_s2 && !dm_s2;
    // NRZI: no change in level means 1, a transition means 0.
    nrzi_bit   = (dp_s2 == prev_sample);
    shift_next = {nrzi_bit, shift[7:1]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      timer        <= 3'd0;
      prev_sample  <= 1'b0;
      shift        <= 8'h00;
      bit_cnt      <= 3'd0;
      ones         <= 3'd0;
      we_hold      <= 1'b0;
      rx_data      <= 8'h00;
      write_enable <= 1'b0;
      eop          <= 1'b0;
      rcv_error    <= 1'b0;
    end else begin
      // Strobe lasts two clk: the set cycle plus one held cycle.
      if (we_hold) begin
        we_hold <= 1'b0;
      end else begin
        write_enable <= 1'b0;
      end

      // While a packet is being decoded, every D+ transition re-centres the sample point.
      if ((state == SYNC || state == RECEIVE) && dp_edge) begin
        timer <= 3'd0;
      end else begin
        timer <= timer + 3'd1;
      end

      case (state)
        IDLE: begin
          timer <= 3'd0;
          // J->K from idle starts the sync pattern; anything else is line noise here.
          if (dp_prev && !dp_s2 && dm_s2) begin
            state       <= SYNC;
            prev_sample <= 1'b1;
            shift       <= 8'h00;
            bit_cnt     <= 3'd0;
            ones        <= 3'd0;
          end
        end

        SYNC, RECEIVE: begin
          if (sample) begin
            if (se0) begin
              // A byte completed on an earlier sample has already been written;
              // only a partial byte or an unfinished sync is an error.
              eop   <= 1'b1;
              state <= EOP_WAIT;
              if (state == SYNC || bit_cnt != 3'd0) begin
                rcv_error <= 1'b1;
              end
            end else begin
              prev_sample <= dp_s2;
              if (ones == 3'd6) begin
                if (nrzi_bit) begin
                  // Seventh 1 in a row: stuffing violated, drop the partial byte.
                  rcv_error <= 1'b1;
                  state     <= ERR_WAIT;
                end else begin
                  // Stuffed 0: discarded, not counted as a kept bit.
                  ones <= 3'd0;
                end
              end else begin
                ones    <= nrzi_bit ? ones + 3'd1 : 3'd0;
                shift   <= shift_next;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  if (state == SYNC) begin
                    if (shift_next == 8'h80) begin
                      state     <= RECEIVE;
                      rcv_error <= 1'b0;
                    end else begin
                      rcv_error <= 1'b1;
                      state     <= ERR_WAIT;
                    end
                  end else begin
                    rx_data      <= shift_next;
                    write_enable <= 1'b1;
                    we_hold      <= 1'b1;
                  end
                end
              end
            end
          end
        end

        ERR_WAIT: begin
          // Data is ignored until the packet ends.
          if (sample && se0) begin
            eop   <= 1'b1;
            state <= EOP_WAIT;
            if (bit_cnt != 3'd0) begin
              rcv_error <= 1'b1;
            end
          end
        end

        EOP_WAIT: begin
          if (sample && line_j) begin
            eop   <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_front.sv
// Bench for usb_rx_front: table of directed packets, hand-written reset/recovery sequences, then random packets vs a packet-level model.
// Line stimulus is built from bytes (stuffing + NRZI), played at 8 clk per bit; a negedge monitor records writes and eop pulses.
// Expected results come from packet-level rules: bad sync -> no writes + error; good sync -> all full bytes written, error iff a partial byte.
module tb_usb_rx_front;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_plus;
  logic       d_minus;
  logic [7:0] rx_data;
  logic       write_enable;
  logic       eop;
  logic       rcv_error;

  always #5 clk = ~clk;

  usb_rx_front dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .rx_data      (rx_data),
    .write_enable (write_enable),
    .eop          (eop),
    .rcv_error    (rcv_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] wr_q[$];
  int  eop_cnt = 0;
  int  eop_run = 0;
  int  eop_len_last = 0;
  int  we_run = 0;
  int  len_bad = 0;
  int  both_bad = 0;
  int  gap_bad = 0;
  int  cyc = 0;
  int  last_we = 0;
  bit  have_we = 1'b0;
  bit  we_q = 1'b0;
  bit  eop_q = 1'b0;

  always @(negedge clk) begin
    if (write_enable && !we_q) begin
      wr_q.push_back(rx_data);
      if (have_we && (cyc - last_we) < 64) gap_bad++;
      last_we = cyc;
      have_we = 1'b1;
      we_run  = 0;
    end
    if (write_enable) we_run++;
    else if (we_q && we_run != 2) len_bad++;
    if (eop) begin
      if (!eop_q) begin
        eop_cnt++;
        eop_run = 0;
      end
      eop_run++;
    end else if (eop_q) begin
      eop_len_last = eop_run;
    end
    if (write_enable && eop) both_bad++;
    we_q  = write_enable;
    eop_q = eop;
    cyc++;
  end

  // ---------------- line encoder / player ----------------
  logic [7:0] pb[$];      // data bytes of the packet
  logic [7:0] exp_q[$];   // bytes expected to be written
  logic [1:0] lv[$];      // {d_plus, d_minus} per bit time
  logic       err_trace[$];

  task automatic build(input logic [7:0] sync, input bit nostuff, input int tail, input logic [7:0] tbits);
    bit bits[$];
    int run;
    bit lvl;
    lv.delete();
    for (int i = 0; i < 8; i++) bits.push_back(sync[i]);
    foreach (pb[k]) for (int i = 0; i < 8; i++) bits.push_back(pb[k][i]);
    for (int i = 0; i < tail; i++) bits.push_back(tbits[i]);
    run = 0;
    lvl = 1'b1;
    foreach (bits[k]) begin
      if (!bits[k]) lvl = !lvl;
      lv.push_back({lvl, !lvl});
      run = bits[k] ? run + 1 : 0;
      if (run == 6 && !nostuff) begin
        lvl = !lvl;
        lv.push_back({lvl, !lvl});
        run = 0;
      end
    end
    repeat (2) lv.push_back(2'b00);
    repeat (4) lv.push_back(2'b10);
  endtask

  task automatic play(input bit glitch, input int limit);
    int n;
    err_trace.delete();
    n = (limit < 0 || limit > lv.size()) ? lv.size() : limit;
    @(posedge clk); #2;
    if (glitch) begin
      // short K: starts the receiver, then J defines the first bit cell
      d_plus = 1'b0; d_minus = 1'b1;
      repeat (3) @(posedge clk);
      #2;
    end
    for (int k = 0; k < n; k++) begin
      {d_plus, d_minus} = lv[k];
      repeat (7) @(posedge clk);
      @(negedge clk);
      err_trace.push_back(rcv_error);
      @(posedge clk); #2;
    end
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] sync, input bit glitch, input bit nostuff,
                         input int tail, input logic [7:0] tbits, input bit exp_err);
    int b_wr, b_eop, b_len, b_both, b_gap;
    repeat (16) @(posedge clk);
    b_wr = wr_q.size(); b_eop = eop_cnt; b_len = len_bad; b_both = both_bad; b_gap = gap_bad;
    build(sync, nostuff, tail, tbits);
    play(glitch, -1);
    @(negedge clk);
    check($sformatf("%s.nwrites", tag), wr_q.size() - b_wr, exp_q.size());
    for (int i = 0; i < exp_q.size() && b_wr + i < wr_q.size(); i++)
      check($sformatf("%s.byte%0d", tag, i), wr_q[b_wr + i], exp_q[i]);
    check($sformatf("%s.rcv_error", tag), rcv_error, exp_err);
    check($sformatf("%s.eop_pulses", tag), eop_cnt - b_eop, 1);
    check($sformatf("%s.eop_len_ok(len=%0d)", tag, eop_len_last), (eop_len_last >= 14 && eop_len_last <= 18), 1);
    check($sformatf("%s.eop_low_after", tag), eop, 0);
    check($sformatf("%s.we_len_bad", tag), len_bad - b_len, 0);
    check($sformatf("%s.we_eop_overlap", tag), both_bad - b_both, 0);
    check($sformatf("%s.we_gap_bad", tag), gap_bad - b_gap, 0);
  endtask

  // Packet-level reference: outcome follows from the sync byte and whether a partial byte remains.
  task automatic model(input logic [7:0] sync, input int tail, output bit err);
    exp_q.delete();
    if (sync != 8'h80) begin
      err = 1'b1;
    end else begin
      foreach (pb[k]) exp_q.push_back(pb[k]);
      err = (tail != 0);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] sync;
    bit         glitch;
    bit         nostuff;
    int         nb;
    logic [7:0] b0, b1, b2;
    int         tail;
    logic [7:0] tbits;
    int         nw;
    logic [7:0] e0, e1, e2;
    bit         err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int b_wr;
    bit merr;
    logic [7:0] bs[3];
    logic [7:0] es[3];
    logic [7:0] s;
    int nb, tail;

    vecs[0] = '{8'h80, 1'b0, 1'b0, 1, 8'h69, 8'h00, 8'h00, 0, 8'h00, 1, 8'h69, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h80, 1'b0, 1'b0, 2, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 2, 8'hFF, 8'h01, 8'h00, 1'b0};
    vecs[2] = '{8'h80, 1'b0, 1'b1, 1, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{8'h80, 1'b0, 1'b0, 3, 8'h00, 8'hA5, 8'h7E, 0, 8'h00, 3, 8'h00, 8'hA5, 8'h7E, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 1, 8'h55, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 3, 8'h05, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 8'h00, 5, 8'h0A, 1, 8'h3C, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{8'h80, 1'b0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0};

    // reset and idle J
    n_rst = 1'b0; d_plus = 1'b1; d_minus = 1'b0;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("idle.write_enable", write_enable, 0);
    check("idle.eop", eop, 0);
    check("idle.rcv_error", rcv_error, 0);
    check("idle.rx_data", rx_data, 8'h00);

    foreach (vecs[v]) begin
      bs = '{vecs[v].b0, vecs[v].b1, vecs[v].b2};
      es = '{vecs[v].e0, vecs[v].e1, vecs[v].e2};
      pb.delete();
      exp_q.delete();
      for (int i = 0; i < vecs[v].nb; i++) pb.push_back(bs[i]);
      for (int i = 0; i < vecs[v].nw; i++) exp_q.push_back(es[i]);
      run_pkt($sformatf("vec%0d", v), vecs[v].sync, vecs[v].glitch, vecs[v].nostuff,
              vecs[v].tail, vecs[v].tbits, vecs[v].err);
    end

    // stuff error, then a good packet must clear the error at its sync byte
    pb = '{8'hFF}; exp_q.delete();
    run_pkt("stufferr", 8'h80, 1'b0, 1'b1, 0, 8'h00, 1'b1);
    pb = '{8'hE1}; exp_q = '{8'hE1};
    run_pkt("recover", 8'h80, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    check("recover.err_before_sync_done", err_trace[5], 1);
    check("recover.err_after_sync", err_trace[9], 0);

    // reset in the middle of a packet after 4 data bits
    repeat (16) @(posedge clk);
    b_wr = wr_q.size();
    pb.delete();
    build(8'h80, 1'b0, 4, 8'h0A);
    play(1'b0, 12);
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst.rx_data", rx_data, 8'h00);
    check("midrst.write_enable", write_enable, 0);
    check("midrst.eop", eop, 0);
    check("midrst.rcv_error", rcv_error, 0);
    d_plus = 1'b1; d_minus = 1'b0;
    repeat (4) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("midrst.no_writes", wr_q.size() - b_wr, 0);
    check("midrst.eop_after", eop, 0);
    check("midrst.err_after", rcv_error, 0);
    pb = '{8'hA5}; exp_q = '{8'hA5};
    run_pkt("after_rst", 8'h80, 1'b0, 1'b0, 0, 8'h00, 1'b0);

    // random packets against the packet-level model
    for (int r = 0; r < 20; r++) begin
      nb = $urandom_range(0, 3);
      pb.delete();
      for (int i = 0; i < nb; i++) pb.push_back(8'($urandom_range(0, 255)));
      tail = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
      if ($urandom_range(0, 3) != 0) begin
        s = 8'h80;
      end else begin
        s = 8'($urandom_range(0, 255)) & 8'hFE;
        if (s == 8'h80) s = 8'h00;
      end
      model(s, tail, merr);
      run_pkt($sformatf("rnd%0d", r), s, 1'b0, 1'b0, tail, 8'($urandom_range(0, 255)), merr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
